// File: rtl/fp_pkg.sv
// Shared floating-point package: class enum, flag indices and format helpers.
// The IEEE754 macro gives the packed {sign, exp, mant} layout for any format.
`ifndef FP_PKG_IEEE754
`define FP_PKG_IEEE754
`define IEEE754(NX, NM) struct packed { \
  logic sign; \
  logic [(NX)-1:0] exp; \
  logic [(NM)-1:0] mant; \
}
`endif

package fp_pkg;

  localparam int FLG_NV = 3;
  localparam int FLG_OF = 2;
  localparam int FLG_UF = 1;
  localparam int FLG_NX = 0;

  typedef enum logic [2:0] {
    FC_ZERO,
    FC_NORM,
    FC_INF,
    FC_QNAN,
    FC_SNAN
  } fclass_t;

  function automatic int EXP_OFFSET(int nx);
    return (1 << (nx - 1)) - 1;
  endfunction

  // Wide result; callers keep the low 1+NX+NM bits.
  function automatic logic [127:0] FP_QNAN(int nx, int nm);
    logic [127:0] r;
    r = '0;
    r = r | (((128'd1 << nx) - 128'd1) << nm);
    r = r | (128'd1 << (nm - 1));
    return r;
  endfunction

  // Subnormals fall into FC_ZERO: they are flushed.
  function automatic fclass_t fp_classify(
    input logic exp_zero,
    input logic exp_ones,
    input logic mant_zero,
    input logic mant_msb
  );
    fclass_t c;
    c = FC_NORM;
    if (exp_zero) c = FC_ZERO;
    else if (exp_ones && mant_zero) c = FC_INF;
    else if (exp_ones && mant_msb) c = FC_QNAN;
    else if (exp_ones) c = FC_SNAN;
    return c;
  endfunction

endpackage

// File: rtl/fp_round_pack.sv
// Normalise, round-to-nearest-even and pack a raw significand product.
// Saturates to inf on overflow and flushes to zero on underflow.
module fp_round_pack
  import fp_pkg::*;
#(
  parameter int NX = 8,
  parameter int NM = 23
) (
  input  logic                 sign,
  input  logic signed [NX+1:0] e,
  input  logic [2*NM+1:0]      p,
  output logic [NX+NM:0]       z,
  output logic [3:0]           flags
);

  localparam int EW = NX + 2;
  localparam logic signed [EW-1:0] E_ONE  = EW'(1);
  localparam logic signed [EW-1:0] E_ZERO = '0;
  localparam logic signed [EW-1:0] E_MAX  = EW'((1 << NX) - 1);

  logic [NM-1:0]          frac;
  logic                   g;
  logic                   s;
  logic                   inc;
  logic [NM:0]            sum;
  logic signed [EW-1:0]   en;
  logic signed [EW-1:0]   er;

  always_comb begin
    if (p[2*NM+1]) begin
      frac = p[2*NM:NM+1];
      g    = p[NM];
      s    = |p[NM-1:0];
      en   = e + E_ONE;
    end else begin
      frac = p[2*NM-1:NM];
      g    = p[NM-1];
      s    = |p[NM-2:0];
      en   = e;
    end
    inc = g & (s | frac[0]);
    sum = {1'b0, frac} + {{NM{1'b0}}, inc};
    // A carry leaves the fraction at zero already.
    er  = sum[NM] ? en + E_ONE : en;

    z     = {sign, er[NX-1:0], sum[NM-1:0]};
    flags = '0;
    flags[FLG_NX] = g | s;
    if (er >= E_MAX) begin
      z = {sign, {NX{1'b1}}, {NM{1'b0}}};
      flags[FLG_OF] = 1'b1;
      flags[FLG_NX] = 1'b1;
    end else if (er <= E_ZERO) begin
      z = {sign, {NX{1'b0}}, {NM{1'b0}}};
      flags[FLG_UF] = 1'b1;
      flags[FLG_NX] = 1'b1;
    end
  end

endmodule

// File: rtl/fp_mul_pipe.sv
// Three-stage IEEE-754 multiplier: unpack, multiply, round/pack.
// Whole pipe advances together; backpressure stalls every stage.
module fp_mul_pipe
  import fp_pkg::*;
#(
  parameter int NX = 8,
  parameter int NM = 23
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [NX+NM:0] in_a,
  input  logic [NX+NM:0] in_b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [NX+NM:0] out_z,
  output logic [3:0]     out_flags
);

  localparam int W  = 1 + NX + NM;
  localparam int EW = NX + 2;
  localparam int PW = 2 * NM + 2;
  localparam logic [127:0] QNAN_W = FP_QNAN(NX, NM);
  localparam logic [W-1:0] QNAN   = QNAN_W[W-1:0];
  localparam logic signed [EW-1:0] E_OFF = EW'(EXP_OFFSET(NX));

  typedef `IEEE754(NX, NM) fp_t;

  fp_t a;
  fp_t b;
  assign a = in_a;
  assign b = in_b;

  logic adv;
  assign adv      = out_ready | ~out_valid;
  assign in_ready = adv;

  fclass_t              ca;
  fclass_t              cb;
  logic signed [EW-1:0] e_in;

  assign ca = fp_classify(a.exp == '0, &a.exp,
                          a.mant == '0, a.mant[NM-1]);
  assign cb = fp_classify(b.exp == '0, &b.exp,
                          b.mant == '0, b.mant[NM-1]);
  assign e_in = $signed({2'b00, a.exp})
              + $signed({2'b00, b.exp}) - E_OFF;

  logic                 v1, v2;
  logic                 s1_sign, s2_sign;
  logic signed [EW-1:0] s1_e, s2_e;
  logic [NM:0]          s1_ma, s1_mb;
  logic [PW-1:0]        s2_p;
  fclass_t              s1_ca, s1_cb, s2_ca, s2_cb;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1      <= 1'b0;
      s1_sign <= 1'b0;
      s1_e    <= '0;
      s1_ma   <= '0;
      s1_mb   <= '0;
      s1_ca   <= FC_ZERO;
      s1_cb   <= FC_ZERO;
      v2      <= 1'b0;
      s2_sign <= 1'b0;
      s2_e    <= '0;
      s2_p    <= '0;
      s2_ca   <= FC_ZERO;
      s2_cb   <= FC_ZERO;
    end else if (adv) begin
      v1      <= in_valid;
      s1_sign <= a.sign ^ b.sign;
      s1_e    <= e_in;
      s1_ma   <= {1'b1, a.mant};
      s1_mb   <= {1'b1, b.mant};
      s1_ca   <= ca;
      s1_cb   <= cb;
      v2      <= v1;
      s2_sign <= s1_sign;
      s2_e    <= s1_e;
      s2_p    <= PW'(s1_ma) * PW'(s1_mb);
      s2_ca   <= s1_ca;
      s2_cb   <= s1_cb;
    end
  end

  logic [W-1:0] rp_z;
  logic [3:0]   rp_f;

  fp_round_pack #(.NX(NX), .NM(NM)) u_round_pack (
    .sign  (s2_sign),
    .e     (s2_e),
    .p     (s2_p),
    .z     (rp_z),
    .flags (rp_f)
  );

  logic         any_nan, any_snan, any_inf;
  logic         any_zero, inf_zero;
  logic         c_nan, c_inf, c_zero, c_norm;
  logic [W-1:0] z_nx;
  logic [3:0]   f_nx;

  always_comb begin
    any_nan  = (s2_ca inside {FC_QNAN, FC_SNAN})
             | (s2_cb inside {FC_QNAN, FC_SNAN});
    any_snan = (s2_ca == FC_SNAN) | (s2_cb == FC_SNAN);
    any_inf  = (s2_ca == FC_INF) | (s2_cb == FC_INF);
    any_zero = (s2_ca == FC_ZERO) | (s2_cb == FC_ZERO);
    inf_zero = any_inf & any_zero;
    c_nan    = any_nan | inf_zero;
    c_inf    = ~c_nan & any_inf;
    c_zero   = ~c_nan & ~any_inf & any_zero;
    c_norm   = ~c_nan & ~any_inf & ~any_zero;
    z_nx     = rp_z;
    f_nx     = rp_f;
    unique case (1'b1)
      c_nan: begin
        z_nx = QNAN;
        f_nx = '0;
        f_nx[FLG_NV] = inf_zero | any_snan;
      end
      c_inf: begin
        z_nx = {s2_sign, {NX{1'b1}}, {NM{1'b0}}};
        f_nx = '0;
      end
      c_zero: begin
        z_nx = {s2_sign, {(NX+NM){1'b0}}};
        f_nx = '0;
      end
      c_norm: begin
        z_nx = rp_z;
        f_nx = rp_f;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_z     <= '0;
      out_flags <= '0;
    end else if (adv) begin
      out_valid <= v2;
      out_z     <= z_nx;
      out_flags <= f_nx;
    end
  end

endmodule
